mdu: RTL and testbench

- Execute-stage multiply/divide unit for the pipelined MIPS core.
- Consumes E-stage operands (forwarded rs/rt values) and the decoded MD opcode.
- Holds the architectural HI/LO registers; mfhi/mflo results return to the E-stage result path.
- Provides Busy so the hazard unit stalls D-stage MD instructions while an operation is in flight.

---
 rtl/mdu.sv | 201 ++++++++++++++++++++
 tb/tb_mdu.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/mdu.sv
// mdu: execute-stage multiply/divide unit for the pipelined MIPS core.
//
// Holds the architectural HI/LO registers. A mult/multu/div/divu is started
// from the E stage, and its full result is computed when it is captured. HI/LO
// are updated when the modelled latency has elapsed. Busy lets the hazard unit
// stall later MD instructions in the D stage.
//
// Parameters:
//   MULT_CYCLES  Busy cycles for mult/multu (>= 1)
//   DIV_CYCLES   Busy cycles for div/divu   (>= 1)
//
// Ports:
//   clk    in   1   system clock, rising edge
//   reset  in   1   synchronous, active-high reset
//   Start  in   1   a mult/multu/div/divu occupies the E stage
//   MDOp   in   4   0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO,
//                   7 MTHI, 8 MTLO, 9-15 NONE
//   A      in   32  rs operand (forwarded)
//   B      in   32  rt operand (forwarded)
//   Busy   out  1   registered, high while an operation is in flight
//   HI     out  32  architectural HI register
//   LO     out  32  architectural LO register
//   Out    out  32  combinational mfhi/mflo read result, else 0

module mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [3:0]  MDOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] Out
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    // Opcode encodings
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    // FSM states
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]    state;
    logic [CW-1:0] count;
    logic [31:0]   hi_tmp;
    logic [31:0]   lo_tmp;
    logic          wr_pend;   // cleared for divide-by-zero so HI/LO are left untouched

    // ------------------------------------------------------------------
    // Operand decode
    // ------------------------------------------------------------------
    logic is_mul;
    logic is_div;
    logic is_signed;
    logic start_ok;

    always_comb begin
        is_mul    = (MDOp == OP_MULT) || (MDOp == OP_MULTU);
        is_div    = (MDOp == OP_DIV)  || (MDOp == OP_DIVU);
        is_signed = (MDOp == OP_MULT) || (MDOp == OP_DIV);
        start_ok  = (state == S_IDLE) && Start && (is_mul || is_div);
    end

    // ------------------------------------------------------------------
    // Multiply: operands are sign- or zero-extended to 64 bits, so one
    // unsigned 64x64 product (low 64 bits) serves both mult and multu.
    // ------------------------------------------------------------------
    logic [63:0] a_ext;
    logic [63:0] b_ext;
    logic [63:0] prod;

    always_comb begin
        a_ext = {{32{is_signed & A[31]}}, A};
        b_ext = {{32{is_signed & B[31]}}, B};
        prod  = a_ext * b_ext;
    end

    // ------------------------------------------------------------------
    // Divide: a single unsigned divider works on the operand magnitudes.
    // The signs are reapplied afterwards, so the quotient truncates toward
    // zero and the remainder follows the dividend. The magnitude of
    // 0x80000000 is still 0x80000000 as an unsigned value, so
    // 0x80000000 / -1 produces 0x80000000 with no overflow special case.
    // ------------------------------------------------------------------
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot;
    logic [31:0] rem;
    logic        div_zero;

    always_comb begin
        a_neg    = is_signed & A[31];
        b_neg    = is_signed & B[31];
        a_mag    = a_neg ? (32'd0 - A) : A;
        b_mag    = b_neg ? (32'd0 - B) : B;
        div_zero = (B == 32'd0);
        q_mag    = '0;
        r_mag    = '0;
        if (!div_zero) begin
            q_mag = a_mag / b_mag;
            r_mag = a_mag % b_mag;
        end
        quot = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
        rem  = a_neg ? (32'd0 - r_mag) : r_mag;
    end

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            count   <= '0;
            Busy    <= 1'b0;
            HI      <= '0;
            LO      <= '0;
            hi_tmp  <= '0;
            lo_tmp  <= '0;
            wr_pend <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_ok) begin
                        if (is_mul) begin
                            hi_tmp  <= prod[63:32];
                            lo_tmp  <= prod[31:0];
                            wr_pend <= 1'b1;
                            count   <= MULT_LOAD;
                        end else begin
                            hi_tmp  <= rem;
                            lo_tmp  <= quot;
                            wr_pend <= !div_zero;
                            count   <= DIV_LOAD;
                        end
                        Busy  <= 1'b1;
                        state <= S_RUN;
                    end else if (MDOp == OP_MTHI) begin
                        // A Start that arrives with MTHI/MTLO is not a valid
                        // launch, so the move still executes.
                        HI <= A;
                    end else if (MDOp == OP_MTLO) begin
                        LO <= A;
                    end
                end
                S_RUN: begin
                    // Start, MTHI and MTLO are all ignored while running.
                    if (count == CNT_ONE) begin
                        if (wr_pend) begin
                            HI <= hi_tmp;
                            LO <= lo_tmp;
                        end
                        wr_pend <= 1'b0;
                        Busy    <= 1'b0;
                        count   <= '0;
                        state   <= S_IDLE;
                    end else begin
                        count <= count - CNT_ONE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    count <= '0;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

    // Read port: reflects committed HI/LO only, never the in-flight result.
    always_comb begin
        Out = '0;
        if (MDOp == OP_MFHI)
            Out = HI;
        else if (MDOp == OP_MFLO)
            Out = LO;
    end

endmodule

// File: tb/tb_mdu.sv
// tb_mdu: directed, self-checking bench for mdu.
//
// Inputs change 1 time unit after a rising edge. Outputs are sampled at that
// same point, so the sampling is well away from the edge.

module tb_mdu;

    logic        clk;
    logic        reset;
    logic        Start;
    logic [3:0]  MDOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] Out;

    int passed;
    int total;

    mdu #(
        .MULT_CYCLES(5),
        .DIV_CYCLES (10)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .Start(Start),
        .MDOp (MDOp),
        .A    (A),
        .B    (B),
        .Busy (Busy),
        .HI   (HI),
        .LO   (LO),
        .Out  (Out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Launches an operation for one cycle and then counts the cycles in which
    // Busy is high, sampled after each edge. If intr_at > 0, a second Start
    // (MULT 1*1) is driven while the counter shows intr_at busy cycles. The
    // loop is bounded so that a stuck Busy cannot hang the run.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int intr_at, output int busy_cycles);
        Start = 1'b1;
        MDOp  = op;
        A     = a;
        B     = b;
        tick();
        Start = 1'b0;
        MDOp  = 4'd0;
        A     = '0;
        B     = '0;
        busy_cycles = 0;
        while (Busy === 1'b1 && busy_cycles < 40) begin
            busy_cycles++;
            if (intr_at > 0 && busy_cycles == intr_at) begin
                Start = 1'b1;
                MDOp  = 4'd1;
                A     = 32'd1;
                B     = 32'd1;
            end else begin
                Start = 1'b0;
                MDOp  = 4'd0;
            end
            tick();
        end
        Start = 1'b0;
        MDOp  = 4'd0;
    endtask

    initial begin
        int n;
        passed = 0;
        total  = 0;
        reset  = 1'b1;
        Start  = 1'b0;
        MDOp   = 4'd0;
        A      = '0;
        B      = '0;

        // Reset followed by idle cycles
        tick();
        tick();
        reset = 1'b0;
        tick();
        tick();
        tick();
        check("rst_busy", {31'd0, Busy}, 32'd0);
        check("rst_hi", HI, 32'd0);
        check("rst_lo", LO, 32'd0);
        MDOp = 4'd5; #1;
        check("rst_mfhi", Out, 32'd0);
        MDOp = 4'd6; #1;
        check("rst_mflo", Out, 32'd0);
        MDOp = 4'd0;

        // MULT -2 * 3
        run_op(4'd1, 32'hFFFF_FFFE, 32'd3, 0, n);
        check("mult_busy", n, 32'd5);
        check("mult_hi", HI, 32'hFFFF_FFFF);
        check("mult_lo", LO, 32'hFFFF_FFFA);

        // MULTU 0xFFFFFFFE * 3
        run_op(4'd2, 32'hFFFF_FFFE, 32'd3, 0, n);
        check("multu_busy", n, 32'd5);
        check("multu_hi", HI, 32'h0000_0002);
        check("multu_lo", LO, 32'hFFFF_FFFA);

        // DIV -7 / 2
        run_op(4'd3, 32'hFFFF_FFF9, 32'd2, 0, n);
        check("div_busy", n, 32'd10);
        check("div_lo", LO, 32'hFFFF_FFFD);
        check("div_hi", HI, 32'hFFFF_FFFF);

        // DIVU 7 / 2
        run_op(4'd4, 32'd7, 32'd2, 0, n);
        check("divu_busy", n, 32'd10);
        check("divu_lo", LO, 32'd3);
        check("divu_hi", HI, 32'd1);

        // MTHI with Start=0, then MTLO with a stray Start=1 (the move still executes)
        MDOp = 4'd7; A = 32'h1234_5678;
        tick();
        Start = 1'b1; MDOp = 4'd8; A = 32'h9ABC_DEF0;
        tick();
        Start = 1'b0;
        check("mt_busy", {31'd0, Busy}, 32'd0);
        MDOp = 4'd5; #1;
        check("mfhi", Out, 32'h1234_5678);
        MDOp = 4'd6; #1;
        check("mflo", Out, 32'h9ABC_DEF0);
        MDOp = 4'd7; #1;
        check("out_other", Out, 32'd0);

        // An out-of-range opcode with Start is ignored
        Start = 1'b1; MDOp = 4'hF; A = 32'hDEAD_BEEF; B = 32'd1;
        tick();
        Start = 1'b0; MDOp = 4'd0;
        check("op15_busy", {31'd0, Busy}, 32'd0);
        check("op15_hi", HI, 32'h1234_5678);

        // Divide by zero: full latency, HI/LO keep their values
        run_op(4'd3, 32'd100, 32'd0, 0, n);
        check("dz_busy", n, 32'd10);
        check("dz_hi", HI, 32'h1234_5678);
        check("dz_lo", LO, 32'h9ABC_DEF0);

        // Reset during the third busy cycle of MULT 4*5
        Start = 1'b1; MDOp = 4'd1; A = 32'd4; B = 32'd5;
        tick();
        Start = 1'b0; MDOp = 4'd0;
        check("abort_busy1", {31'd0, Busy}, 32'd1);
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_busy", {31'd0, Busy}, 32'd0);
        check("abort_hi", HI, 32'd0);
        check("abort_lo", LO, 32'd0);
        for (int i = 0; i < 8; i++) tick();
        check("abort_hi_late", HI, 32'd0);
        check("abort_lo_late", LO, 32'd0);
        check("abort_busy_late", {31'd0, Busy}, 32'd0);

        // DIV 0x80000000 / -1, with a second Start during Busy that must be ignored
        run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 3, n);
        check("ovf_busy", n, 32'd10);
        check("ovf_lo", LO, 32'h8000_0000);
        check("ovf_hi", HI, 32'd0);
        tick();
        check("ovf_idle", {31'd0, Busy}, 32'd0);
        check("ovf_lo_hold", LO, 32'h8000_0000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
